spi_flash_responder: RTL and testbench
======================================

// Module: spi_flash_responder
// PURPOSE
//  SPI mode-0 flash responder (slave): the device end of the bootloader's flash link.
//  Decodes a subset of serial-flash opcodes and serves read data from a word-less
//  byte memory port, so a board can emulate/passthrough config flash and benches can
//  run the bootloader against RTL rather than a behavioural model.
//  SCK/CS/MOSI are oversampled in the clk_48mhz domain (SCK <= clk_48mhz/4).
// PARAMETERS
//  JEDEC_ID   24'hEF4016  bytes returned MSB-first by opcode 0x9F
//  ADDR_W     24          width of mem_addr; low ADDR_W bits of the 24-bit flash address
//  STATUS_VAL 8'h00       value returned by opcode 0x05 (BUSY bit always 0)
// PORTS
//  clk_48mhz    in   1       sole clock
//  reset        in   1       synchronous, active-high
//  spi_sck      in   1       async SPI clock from master
//  spi_cs       in   1       async chip select, active-low
//  spi_mosi     in   1       async master data
//  spi_miso     out  1       responder data, changes after SCK falling edge
//  spi_miso_oe  out  1       1 only while a response byte is being shifted
//  mem_addr     out  ADDR_W  byte address of pending read
//  mem_rd_req   out  1       read request; held until mem_rd_ack
//  mem_rd_ack   in   1       one-cycle: mem_rd_data valid
//  mem_rd_data  in   8       read byte
//  powered_down out  1       deep-power-down flag (0xB9 sets, 0xAB clears)
//  underrun     out  1       one-cycle pulse: data byte not ready at load point
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift regs cleared, powered_down 0.
//  Input sync: 2 flops on sck/cs/mosi + 1 history flop on sck; sck_rise/sck_fall are
//   single-cycle pulses; mosi sampled on sck_rise; miso updated on sck_fall. ~3 clk lag.
//  Bits MSB-first; bit counter 0..7; byte completes on 8th sck_rise.
//  cs high (synced) -> IDLE next cycle from any state, bit counter 0, miso_oe 0,
//   miso 0; mid-byte partial bits discarded.
//  FSM: IDLE -> CMD on cs low. CMD byte decode:
//   0x03 READ  -> ADDR(3 bytes) -> DATA
//   0x0B FREAD -> ADDR(3) -> DUMMY(1) -> DATA
//   0x9F JEDEC -> ID (JEDEC_ID bytes 2,1,0, then 0xFF repeating)
//   0x05 RDSR  -> STAT (STATUS_VAL repeating)
//   0xB9 DPD   -> IGNORE; powered_down<=1 on cs rise after exactly 8 bits
//   0xAB RES   -> IGNORE; powered_down<=0 on byte completion
//   other, or any opcode except 0xAB while powered_down -> IGNORE (miso_oe 0).
//  Response load: on the sck_fall following the byte that ends CMD/ADDR/DUMMY or a
//   data byte, shift reg loads next byte and drives its MSB; miso_oe<=1.
//  DATA: mem_rd_req asserted the cycle after address completes, then again one cycle
//   after each byte is loaded; mem_addr = current address; address +1 per load,
//   24-bit wrap 0xFFFFFF->0x000000 (mem_addr truncates).
//  Prefetch buffer holds one byte. If buffer empty at load point: load 0xFF, pulse
//   underrun, address still advances.
//  Request outstanding at cs rise: req stays high until ack; acked byte discarded;
//   new transaction's first req waits for that ack.
//  Simultaneous ack and load point in same cycle: ack data is loaded (not underrun).
// STRUCTURE
//  spi_flash_pkg: opcode localparams (OP_READ..OP_RES), state enum
//   {IDLE,CMD,ADDR,DUMMY,DATA,ID,STAT,IGNORE}, byte count widths.
//  Sub-module spi_sync_edge: 2-flop sync + edge pulses for sck, sync for cs/mosi.
//  Top: FSM, bit/byte counters, shift-in/shift-out regs, address reg, prefetch buffer.
// TESTING
//  1 reset mid-READ data byte -> all outputs 0 next cycle, FSM IDLE, next cs-low works.
//  2 0x03 00 01 00, mem returns addr[7:0] with 2-clk ack, 4 bytes read
//    -> MISO 00 01 02 03, mem_addr 0x100..0x103, miso_oe 0 during cmd/addr.
//  3 0x0B FF FF FE + dummy, 3 bytes -> addrs FFFFFE, FFFFFF, 000000; no underrun.
//  4 0x9F, 5 bytes -> EF 40 16 FF FF; 0x05, 2 bytes -> 00 00.
//  5 0xB9 then cs high; 0x9F -> miso_oe 0 throughout; 0xAB; 0x9F -> EF 40 16.
//  6 READ with ack never given -> first data 0xFF, underrun pulse; cs rise with req
//    pending -> req held until late ack, that byte discarded.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_pkg
// Shared definitions for the SPI flash responder: supported opcodes, the
// transaction state encoding, counter widths and the opcode decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_flash_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_JEDEC = 8'h9F;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_DPD   = 8'hB9;
    localparam logic [7:0] OP_RES   = 8'hAB;

    localparam int BIT_CNT_W  = 3;
    localparam int BYTE_CNT_W = 2;

    // Index of the last of the three address bytes
    localparam logic [BYTE_CNT_W-1:0] ADDR_LAST = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DUMMY  = 3'd3,
        DATA   = 3'd4,
        ID     = 3'd5,
        STAT   = 3'd6,
        IGNORE = 3'd7
    } state_t;

    // State entered after the command byte; only RES is honoured while powered down
    function automatic state_t decode_op(input logic [7:0] op, input logic pd);
        state_t st;
        if (pd && (op != OP_RES)) begin
            st = IGNORE;
        end else begin
            case (op)
                OP_READ:  st = ADDR;
                OP_FREAD: st = ADDR;
                OP_JEDEC: st = ID;
                OP_RDSR:  st = STAT;
                default:  st = IGNORE;
            endcase
        end
        return st;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings the asynchronous SPI pins into the clk_48mhz domain with two flops
// each and derives single-cycle SCK edge pulses from one extra history flop.
// Ports:
//   clk_48mhz, reset           clock / synchronous active-high reset
//   spi_sck, spi_cs, spi_mosi  raw pins
//   sck_rise, sck_fall         one-cycle pulses on synchronised SCK edges
//   cs_sync, mosi_sync         synchronised chip select / data
// -----------------------------------------------------------------------------
module spi_sync_edge (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic spi_sck,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_sync,
    output logic mosi_sync
);

    logic [1:0] sck_sync_r;
    logic       sck_hist_r;
    logic [1:0] cs_sync_r;
    logic [1:0] mosi_sync_r;

    // Synchroniser chains; cs resets to deselected so reset never opens a frame
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            sck_sync_r  <= 2'b00;
            sck_hist_r  <= 1'b0;
            cs_sync_r   <= 2'b11;
            mosi_sync_r <= 2'b00;
        end else begin
            sck_sync_r  <= {sck_sync_r[0], spi_sck};
            sck_hist_r  <= sck_sync_r[1];
            cs_sync_r   <= {cs_sync_r[0], spi_cs};
            mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
        end
    end

    assign sck_rise  =  sck_sync_r[1] & ~sck_hist_r;
    assign sck_fall  = ~sck_sync_r[1] &  sck_hist_r;
    assign cs_sync   =  cs_sync_r[1];
    assign mosi_sync =  mosi_sync_r[1];

endmodule

// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
// SPI mode-0 serial-flash slave serving READ/FREAD from a byte memory port,
// plus JEDEC ID, status read and deep-power-down / release.
// Ports:
//   clk_48mhz, reset          clock / synchronous active-high reset
//   spi_sck/cs/mosi           async SPI inputs (cs active-low)
//   spi_miso, spi_miso_oe     response data and its output enable
//   mem_addr, mem_rd_req      read request, held until mem_rd_ack
//   mem_rd_ack, mem_rd_data   one-cycle read completion and data
//   powered_down              deep-power-down flag
//   underrun                  pulse when a data byte was not ready in time
// -----------------------------------------------------------------------------
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
    parameter int          ADDR_W     = 24,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              clk_48mhz,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic [7:0]        mem_rd_data,
    output logic              powered_down,
    output logic              underrun
);

    state_t                state_r, state_next_s;
    logic                  sck_rise_s, sck_fall_s, cs_s, mosi_s;
    logic [BIT_CNT_W-1:0]  bit_cnt_r;
    logic [BYTE_CNT_W-1:0] byte_cnt_r;
    logic [6:0]            shift_in_r;
    logic [7:0]            shift_out_r, rx_byte_s, buf_r, id_byte_s, load_byte_s;
    logic                  buf_valid_r, fread_r, want_r, discard_r, dpd_armed_r;
    logic [23:0]           addr_r, addr_next_s;
    logic                  byte_done_s, load_s, addr_done_s, ack_use_s;
    logic                  want_now_s, issue_s, underrun_s;
    logic                  miso_oe_r, req_r, powered_down_r, underrun_r;
    logic [ADDR_W-1:0]     mem_addr_r;

    spi_sync_edge u_sync (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .sck_rise  (sck_rise_s),
        .sck_fall  (sck_fall_s),
        .cs_sync   (cs_s),
        .mosi_sync (mosi_s)
    );

    // Byte framing, response-load point, address stepping and memory-request decisions
    always_comb begin
        rx_byte_s   = {shift_in_r, mosi_s};
        byte_done_s = !cs_s && sck_rise_s && (bit_cnt_r == 3'd7);
        // Bit counter is back at 0 only on the fall right after a completed byte
        load_s      = !cs_s && sck_fall_s && (bit_cnt_r == 3'd0) &&
                      ((state_r == DATA) || (state_r == ID) || (state_r == STAT));
        addr_done_s = (state_r == ADDR) && byte_done_s && (byte_cnt_r == ADDR_LAST);
        ack_use_s   = mem_rd_ack && req_r && !discard_r && !cs_s;
        want_now_s  = addr_done_s || ((state_r == DATA) && load_s);
        // One outstanding request, and only into a buffer that is free this cycle
        issue_s     = (want_now_s || want_r) && !req_r && (!buf_valid_r || load_s) && !cs_s;

        if ((state_r == ADDR) && byte_done_s) begin
            addr_next_s = {addr_r[15:0], rx_byte_s};
        end else if ((state_r == DATA) && load_s) begin
            addr_next_s = addr_r + 24'd1;
        end else begin
            addr_next_s = addr_r;
        end

        case (byte_cnt_r)
            2'd0:    id_byte_s = JEDEC_ID[23:16];
            2'd1:    id_byte_s = JEDEC_ID[15:8];
            2'd2:    id_byte_s = JEDEC_ID[7:0];
            default: id_byte_s = 8'hFF;
        endcase

        underrun_s = 1'b0;
        case (state_r)
            DATA: begin
                if (buf_valid_r) begin
                    load_byte_s = buf_r;
                end else if (ack_use_s) begin
                    load_byte_s = mem_rd_data;
                end else begin
                    load_byte_s = 8'hFF;
                    underrun_s  = 1'b1;
                end
            end
            ID:      load_byte_s = id_byte_s;
            STAT:    load_byte_s = STATUS_VAL;
            default: load_byte_s = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; deselect returns to IDLE from anywhere
    always_comb begin
        state_next_s = state_r;
        if (cs_s) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:  state_next_s = CMD;
                CMD:   state_next_s = byte_done_s ? decode_op(rx_byte_s, powered_down_r) : CMD;
                ADDR:  state_next_s = addr_done_s ? (fread_r ? DUMMY : DATA) : ADDR;
                DUMMY: state_next_s = byte_done_s ? DATA : DUMMY;
                default: state_next_s = state_r;
            endcase
        end
    end

    // Datapath: shifters, counters, address, prefetch buffer, memory handshake, flags
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            bit_cnt_r      <= 3'd0;
            byte_cnt_r     <= 2'd0;
            shift_in_r     <= 7'd0;
            shift_out_r    <= 8'd0;
            miso_oe_r      <= 1'b0;
            addr_r         <= 24'd0;
            buf_r          <= 8'd0;
            buf_valid_r    <= 1'b0;
            fread_r        <= 1'b0;
            want_r         <= 1'b0;
            discard_r      <= 1'b0;
            dpd_armed_r    <= 1'b0;
            req_r          <= 1'b0;
            mem_addr_r     <= '0;
            powered_down_r <= 1'b0;
            underrun_r     <= 1'b0;
        end else begin
            underrun_r <= load_s && underrun_s;

            // The handshake outlives the frame: a request is only dropped by its ack
            if (req_r && mem_rd_ack) begin
                req_r <= 1'b0;
            end else if (issue_s) begin
                req_r      <= 1'b1;
                mem_addr_r <= addr_next_s[ADDR_W-1:0];
            end
            if (req_r && mem_rd_ack) begin
                discard_r <= 1'b0;
            end else if (cs_s && req_r) begin
                discard_r <= 1'b1;
            end

            if (cs_s) begin
                bit_cnt_r   <= 3'd0;
                byte_cnt_r  <= 2'd0;
                shift_in_r  <= 7'd0;
                shift_out_r <= 8'd0;
                miso_oe_r   <= 1'b0;
                addr_r      <= 24'd0;
                buf_valid_r <= 1'b0;
                fread_r     <= 1'b0;
                want_r      <= 1'b0;
                dpd_armed_r <= 1'b0;
                if (dpd_armed_r) begin
                    powered_down_r <= 1'b1;
                end
            end else begin
                if (sck_rise_s) begin
                    bit_cnt_r  <= bit_cnt_r + 3'd1;
                    shift_in_r <= rx_byte_s[6:0];
                end
                addr_r <= addr_next_s;
                want_r <= (want_now_s || want_r) && !issue_s;

                if (load_s) begin
                    shift_out_r <= load_byte_s;
                    miso_oe_r   <= 1'b1;
                end else if (sck_fall_s) begin
                    shift_out_r <= {shift_out_r[6:0], 1'b0};
                end

                if (load_s && (state_r == DATA)) begin
                    buf_valid_r <= 1'b0;
                end else if (ack_use_s) begin
                    buf_r       <= mem_rd_data;
                    buf_valid_r <= 1'b1;
                end

                case (state_r)
                    CMD:  byte_cnt_r <= 2'd0;
                    ADDR: if (byte_done_s) byte_cnt_r <= byte_cnt_r + 2'd1;
                    ID:   if (load_s && (byte_cnt_r != 2'd3)) byte_cnt_r <= byte_cnt_r + 2'd1;
                    default: byte_cnt_r <= byte_cnt_r;
                endcase

                // DPD takes effect only if cs rises with no bit after the opcode
                if ((state_r == CMD) && byte_done_s) begin
                    fread_r <= (rx_byte_s == OP_FREAD);
                    if (rx_byte_s == OP_RES) begin
                        powered_down_r <= 1'b0;
                    end
                    if ((rx_byte_s == OP_DPD) && !powered_down_r) begin
                        dpd_armed_r <= 1'b1;
                    end
                end else if ((state_r == IGNORE) && sck_rise_s) begin
                    dpd_armed_r <= 1'b0;
                end
            end
        end
    end

    assign spi_miso     = shift_out_r[7];
    assign spi_miso_oe  = miso_oe_r;
    assign mem_addr     = mem_addr_r;
    assign mem_rd_req   = req_r;
    assign powered_down = powered_down_r;
    assign underrun     = underrun_r;

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

    localparam int HALF = 6;

    logic        clk_48mhz = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sck = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, mem_rd_req, powered_down, underrun;
    logic [23:0] mem_addr;
    logic        mem_rd_ack = 1'b0;
    logic [7:0]  mem_rd_data = 8'h00;

    int checks = 0;
    int errors = 0;
    int ucnt = 0;
    int ack_cnt = 0;
    int ack_delay = 2;
    bit ack_en = 1'b1;
    logic [23:0] ack_log[$];

    spi_flash_responder dut (
        .clk_48mhz    (clk_48mhz),
        .reset        (reset),
        .spi_sck      (spi_sck),
        .spi_cs       (spi_cs),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .mem_addr     (mem_addr),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_ack   (mem_rd_ack),
        .mem_rd_data  (mem_rd_data),
        .powered_down (powered_down),
        .underrun     (underrun)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    // Memory model: ack after ack_delay cycles of request, data = address low byte
    always @(negedge clk_48mhz) begin
        if (underrun) ucnt++;
        if (mem_rd_ack) begin
            mem_rd_ack = 1'b0;
        end else if (mem_rd_req && ack_en) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin
                mem_rd_ack  = 1'b1;
                mem_rd_data = mem_addr[7:0];
                ack_log.push_back(mem_addr);
                ack_cnt = 0;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    typedef struct {
        logic [39:0] hdr;
        int          n_hdr;
        int          n_rd;
        logic [39:0] exp;
        logic        exp_oe;
        logic        exp_pd;
        logic [23:0] addr0;
        bit          chk_addr;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk_48mhz);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx,
                            output logic oe_and, output logic oe_or);
        oe_and = 1'b1;
        oe_or  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            clks(HALF);
            rx[i]  = spi_miso;
            oe_and = oe_and & spi_miso_oe;
            oe_or  = oe_or | spi_miso_oe;
            spi_sck = 1'b1;
            clks(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_cs = 1'b0;
        clks(HALF);
    endtask

    task automatic cs_end();
        clks(HALF);
        spi_cs = 1'b1;
        clks(8);
    endtask

    initial begin
        logic [7:0]  rx;
        logic        oa, oo, hdr_oe;
        int          u0;
        logic [23:0] ea;

        vecs[0] = '{40'h0300010000, 4, 4, 40'h0001020300, 1'b1, 1'b0, 24'h000100, 1'b1};
        vecs[1] = '{40'h0BFFFFFE00, 5, 3, 40'hFEFF000000, 1'b1, 1'b0, 24'hFFFFFE, 1'b1};
        vecs[2] = '{40'h9F00000000, 1, 5, 40'hEF4016FFFF, 1'b1, 1'b0, 24'h000000, 1'b0};
        vecs[3] = '{40'h0500000000, 1, 2, 40'h0000000000, 1'b1, 1'b0, 24'h000000, 1'b0};
        vecs[4] = '{40'hB900000000, 1, 0, 40'h0000000000, 1'b0, 1'b1, 24'h000000, 1'b0};
        vecs[5] = '{40'h9F00000000, 1, 3, 40'h0000000000, 1'b0, 1'b1, 24'h000000, 1'b0};
        vecs[6] = '{40'hAB00000000, 1, 0, 40'h0000000000, 1'b0, 1'b0, 24'h000000, 1'b0};
        vecs[7] = '{40'h9F00000000, 1, 3, 40'hEF40160000, 1'b1, 1'b0, 24'h000000, 1'b0};
        vecs[8] = '{40'h5A00000000, 1, 2, 40'h0000000000, 1'b0, 1'b0, 24'h000000, 1'b0};

        // Reset state
        clks(3);
        chk("reset outputs", {5'd0, spi_miso, spi_miso_oe, mem_addr, mem_rd_req, powered_down, underrun}, 32'd0);
        reset = 1'b0;
        clks(4);

        // Table-driven transactions
        for (int v = 0; v < 9; v++) begin
            ack_log.delete();
            u0 = ucnt;
            cs_begin();
            hdr_oe = 1'b0;
            for (int j = 0; j < vecs[v].n_hdr; j++) begin
                spi_xfer(vecs[v].hdr[39-8*j -: 8], rx, oa, oo);
                hdr_oe = hdr_oe | oo;
            end
            chk($sformatf("v%0d hdr oe", v), {31'd0, hdr_oe}, 32'd0);
            for (int j = 0; j < vecs[v].n_rd; j++) begin
                spi_xfer(8'h00, rx, oa, oo);
                chk($sformatf("v%0d rx%0d", v, j), {24'd0, rx}, {24'd0, vecs[v].exp[39-8*j -: 8]});
                chk($sformatf("v%0d oe%0d", v, j), {30'd0, oa, oo}, {30'd0, vecs[v].exp_oe, vecs[v].exp_oe});
            end
            cs_end();
            chk($sformatf("v%0d powered_down", v), {31'd0, powered_down}, {31'd0, vecs[v].exp_pd});
            if (vecs[v].chk_addr) begin
                chk($sformatf("v%0d underruns", v), ucnt - u0, 32'd0);
                for (int j = 0; j < vecs[v].n_rd; j++) begin
                    ea = vecs[v].addr0 + 24'(j);
                    if (j < ack_log.size()) begin
                        chk($sformatf("v%0d mem_addr%0d", v, j), {8'd0, ack_log[j]}, {8'd0, ea});
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL v%0d mem_addr%0d: got no request expected %h", v, j, ea);
                    end
                end
            end
        end

        // Memory never answers: underrun, then request held across cs rise
        ack_en = 1'b0;
        ack_log.delete();
        u0 = ucnt;
        cs_begin();
        spi_xfer(8'h03, rx, oa, oo);
        spi_xfer(8'h00, rx, oa, oo);
        spi_xfer(8'h00, rx, oa, oo);
        spi_xfer(8'h10, rx, oa, oo);
        spi_xfer(8'h00, rx, oa, oo);
        chk("underrun data", {24'd0, rx}, 32'h0000_00FF);
        cs_end();
        chk("underrun pulses", ucnt - u0, 32'd2);
        chk("req held at cs rise", {31'd0, mem_rd_req}, 32'd1);
        clks(20);
        chk("req still held", {31'd0, mem_rd_req}, 32'd1);

        // Next frame: late ack of the stale request must not leak into the data
        u0 = ucnt;
        cs_begin();
        spi_xfer(8'h03, rx, oa, oo);
        spi_xfer(8'h00, rx, oa, oo);
        spi_xfer(8'h00, rx, oa, oo);
        ack_en = 1'b1;
        spi_xfer(8'h20, rx, oa, oo);
        spi_xfer(8'h00, rx, oa, oo);
        chk("post-stale data", {24'd0, rx}, 32'h0000_0020);
        cs_end();
        chk("post-stale underruns", ucnt - u0, 32'd0);
        if (ack_log.size() >= 2) begin
            chk("stale ack addr", {8'd0, ack_log[0]}, 32'h0000_0010);
            chk("fresh ack addr", {8'd0, ack_log[1]}, 32'h0000_0020);
        end else begin
            checks++;
            errors++;
            $display("FAIL ack log: got %0d acks expected at least 2", ack_log.size());
        end
        for (int k = 0; k < 50 && mem_rd_req; k++) clks(1);
        chk("req released", {31'd0, mem_rd_req}, 32'd0);

        // Reset in the middle of a READ data byte
        cs_begin();
        spi_xfer(8'h03, rx, oa, oo);
        spi_xfer(8'h00, rx, oa, oo);
        spi_xfer(8'h00, rx, oa, oo);
        spi_xfer(8'h80, rx, oa, oo);
        spi_xfer(8'h00, rx, oa, oo);
        chk("pre-reset data", {24'd0, rx}, 32'h0000_0080);
        clks(HALF);
        chk("pre-reset miso/oe", {30'd0, spi_miso, spi_miso_oe}, 32'd3);
        reset  = 1'b1;
        spi_cs = 1'b1;
        clks(1);
        chk("mid-read reset outputs", {5'd0, spi_miso, spi_miso_oe, mem_addr, mem_rd_req, powered_down, underrun}, 32'd0);
        reset = 1'b0;
        clks(6);
        cs_begin();
        spi_xfer(8'h9F, rx, oa, oo);
        spi_xfer(8'h00, rx, oa, oo);
        chk("post-reset id0", {24'd0, rx}, 32'h0000_00EF);
        spi_xfer(8'h00, rx, oa, oo);
        chk("post-reset id1", {24'd0, rx}, 32'h0000_0040);
        spi_xfer(8'h00, rx, oa, oo);
        chk("post-reset id2", {24'd0, rx}, 32'h0000_0016);
        cs_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
